// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB UART transmitter: register offsets,
// CTRL/STATUS bit positions, FSM state encoding, reset constants and the
// frame parity helper.
package apb_uart_pkg;

  // Register offsets (PADDR[11:0])
  localparam logic [11:0] OFF_TXDATA = 12'h000;
  localparam logic [11:0] OFF_STATUS = 12'h004;
  localparam logic [11:0] OFF_CTRL   = 12'h008;
  localparam logic [11:0] OFF_BAUD   = 12'h00C;

  // CTRL bit positions
  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_WLS_LO = 1;
  localparam int CTRL_WLS_HI = 2;
  localparam int CTRL_PEN    = 3;
  localparam int CTRL_EPS    = 4;
  localparam int CTRL_STB    = 5;
  localparam int CTRL_IE     = 6;

  // STATUS bit positions
  localparam int ST_FULL   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_BUSY   = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_LVL_LO = 8;
  localparam int ST_LVL_HI = 15;

  // Reset constants
  localparam logic [6:0] CTRL_RST = 7'h00;
  localparam logic       TXD_RST  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_e;

  // Parity over the wls+5 data bits actually sent; eps=1 gives even parity.
  function automatic logic frame_parity(input logic [7:0] data,
                                        input logic [1:0] wls,
                                        input logic       eps);
    logic [7:0] mask;
    logic       p;
    mask = 8'hFF >> (2'd3 - wls);
    p    = ^(data & mask);
    return eps ? p : ~p;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with level count. Pushes while full and pops while
// empty are ignored; the caller decides what a dropped push means.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (level_q == DEPTH_L);
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign data_o    = mem_q[rd_ptr_q];
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;

  // Storage array write; contents need no reset since level guards reads.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer and level bookkeeping; power-of-two depth lets pointers wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_q <= level_q + (AW + 1)'(1);
        2'b01:   level_q <= level_q - (AW + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/apb_uart_tx.sv
// APB3 UART transmitter: register decode, TX FIFO, baud generator and
// frame FSM. Frame format and divisor are sampled when a frame starts, so
// register writes during a frame only affect later frames.
module apb_uart_tx
  import apb_uart_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              TXD,
  output logic              IRQ,
  output logic              baud_o
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  // APB decode
  logic [11:0]       off_s;
  logic              acc_s;
  logic              wr_s;
  logic              mapped_s;
  logic [DATA_W-1:0] rdata_s;
  logic [15:0]       status_s;
  logic              unused_s;

  // Registers
  logic [6:0]        ctrl_q;
  logic [DIV_W-1:0]  baud_q;
  logic              ovf_q;

  // FIFO
  logic              push_s;
  logic              pop_s;
  logic [7:0]        fifo_dout_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [LVL_W-1:0]  fifo_lvl_s;

  // Frame FSM
  tx_state_e         state_q;
  logic [7:0]        shift_q;
  logic [2:0]        bit_cnt_q;
  logic [1:0]        wls_q;
  logic              pen_q;
  logic              stb_q;
  logic              par_q;
  logic              stop_cnt_q;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  cnt_q;
  logic              txd_q;
  logic              irq_q;
  logic              tick_s;
  logic              stop_last_s;
  logic              start_s;

  assign off_s    = PADDR[11:0];
  assign acc_s    = PSEL && PENABLE;
  assign wr_s     = acc_s && PWRITE;
  assign mapped_s = (off_s == OFF_TXDATA) || (off_s == OFF_STATUS) ||
                    (off_s == OFF_CTRL)   || (off_s == OFF_BAUD);
  assign PSLVERR  = acc_s && !mapped_s;
  assign PREADY   = 1'b1;
  assign PRDATA   = rdata_s;
  assign unused_s = ^{PADDR, PWDATA};

  assign status_s = {8'(fifo_lvl_s), 4'b0000, ovf_q, (state_q != S_IDLE),
                     fifo_empty_s, fifo_full_s};

  assign push_s = wr_s && (off_s == OFF_TXDATA);
  assign pop_s  = start_s;

  // Bit boundary: counter reached the divisor latched for this frame.
  assign tick_s      = (state_q != S_IDLE) && (cnt_q == div_q);
  assign stop_last_s = !stb_q || stop_cnt_q;
  // A new frame starts from IDLE, or straight out of the final stop bit.
  assign start_s     = ctrl_q[CTRL_TX_EN] && !fifo_empty_s &&
                       ((state_q == S_IDLE) ||
                        ((state_q == S_STOP) && tick_s && stop_last_s));

  assign TXD    = txd_q;
  assign IRQ    = irq_q;
  assign baud_o = tick_s;

  // Read mux: only drives data during a read-select, zero otherwise.
  always_comb begin
    rdata_s = '0;
    if (PSEL && !PWRITE) begin
      case (off_s)
        OFF_STATUS: rdata_s[15:0]      = status_s;
        OFF_CTRL:   rdata_s[6:0]       = ctrl_q;
        OFF_BAUD:   rdata_s[DIV_W-1:0] = baud_q;
        default:    rdata_s            = '0;
      endcase
    end else begin
      rdata_s = '0;
    end
  end

  // Register writes; unmapped offsets fall through and change nothing.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl_q <= CTRL_RST;
      baud_q <= '0;
      ovf_q  <= 1'b0;
    end else if (wr_s) begin
      case (off_s)
        OFF_TXDATA: if (fifo_full_s) ovf_q <= 1'b1;
        OFF_STATUS: if (PWDATA[ST_OVF]) ovf_q <= 1'b0;
        OFF_CTRL:   ctrl_q <= PWDATA[6:0];
        OFF_BAUD:   baud_q <= PWDATA[DIV_W-1:0];
        default:    ovf_q  <= ovf_q;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (PCLK),
    .rst_ni  (PRESETn),
    .push_i  (push_s),
    .data_i  (PWDATA[7:0]),
    .pop_i   (pop_s),
    .data_o  (fifo_dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (fifo_lvl_s)
  );

  // Frame FSM with registered TXD and IRQ; TXD changes on the same edge as state.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      wls_q      <= '0;
      pen_q      <= 1'b0;
      stb_q      <= 1'b0;
      par_q      <= 1'b0;
      stop_cnt_q <= 1'b0;
      div_q      <= '0;
      cnt_q      <= '0;
      txd_q      <= TXD_RST;
      irq_q      <= 1'b0;
    end else begin
      if (state_q != S_IDLE) begin
        cnt_q <= tick_s ? '0 : cnt_q + DIV_W'(1);
      end

      if (start_s) begin
        shift_q   <= fifo_dout_s;
        wls_q     <= ctrl_q[CTRL_WLS_HI:CTRL_WLS_LO];
        pen_q     <= ctrl_q[CTRL_PEN];
        stb_q     <= ctrl_q[CTRL_STB];
        par_q     <= frame_parity(fifo_dout_s, ctrl_q[CTRL_WLS_HI:CTRL_WLS_LO],
                                  ctrl_q[CTRL_EPS]);
        div_q     <= baud_q;
        bit_cnt_q <= '0;
        cnt_q     <= '0;
      end

      case (state_q)
        S_IDLE: begin
          if (start_s) begin
            state_q <= S_START;
            txd_q   <= 1'b0;
          end
        end
        S_START: begin
          if (tick_s) begin
            state_q <= S_DATA;
            txd_q   <= shift_q[0];
          end
        end
        S_DATA: begin
          if (tick_s) begin
            if (bit_cnt_q == ({1'b0, wls_q} + 3'd4)) begin
              if (pen_q) begin
                state_q <= S_PARITY;
                txd_q   <= par_q;
              end else begin
                state_q    <= S_STOP;
                txd_q      <= 1'b1;
                stop_cnt_q <= 1'b0;
              end
            end else begin
              shift_q   <= shift_q >> 1;
              txd_q     <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        S_PARITY: begin
          if (tick_s) begin
            state_q    <= S_STOP;
            txd_q      <= 1'b1;
            stop_cnt_q <= 1'b0;
          end
        end
        S_STOP: begin
          if (tick_s) begin
            if (!stop_last_s) begin
              stop_cnt_q <= 1'b1;
            end else if (start_s) begin
              state_q <= S_START;
              txd_q   <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              txd_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          txd_q   <= 1'b1;
        end
      endcase

      irq_q <= ctrl_q[CTRL_IE] && fifo_empty_s && (state_q == S_IDLE);
    end
  end

endmodule

// File: tb/tb_apb_uart_tx.sv
// Self-checking bench for apb_uart_tx: directed steps plus randomized
// frames, compared against a bit-list model of the serial waveform.
module tb_apb_uart_tx;

  logic        PCLK;
  logic        PRESETn;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        TXD;
  logic        IRQ;
  logic        baud_o;

  int   checks;
  int   failures;
  logic exp_q[$];
  logic obs_q[$];

  apb_uart_tx #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .FIFO_DEPTH (16),
    .DIV_W      (16)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PADDR   (PADDR),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .TXD     (TXD),
    .IRQ     (IRQ),
    .baud_o  (baud_o)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic slverr);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    rdata  = PRDATA;
    slverr = PSLVERR;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] r;
    logic        e;
    apb(1'b1, addr, data, r, e);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    logic e;
    apb(1'b0, addr, 32'h0, data, e);
  endtask

  // Model: a frame is the list of line levels, one per bit period.
  task automatic model_frame(input logic [7:0] data, input logic [6:0] ctrl);
    int   nb;
    int   ones;
    logic [1:0] wls;
    wls  = ctrl[2:1];
    nb   = int'(wls) + 5;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      exp_q.push_back(data[i]);
      if (data[i]) ones++;
    end
    if (ctrl[3]) begin
      // even parity makes the total count of ones even, odd makes it odd
      if (ctrl[4]) exp_q.push_back((ones % 2) == 1);
      else         exp_q.push_back((ones % 2) == 0);
    end
    exp_q.push_back(1'b1);
    if (ctrl[5]) exp_q.push_back(1'b1);
  endtask

  // Sample every cycle of the expected frames, starting the cycle after the
  // access that made a frame startable.
  task automatic run_frames(input string tag, input int div);
    int per;
    int ncyc;
    int bad;
    int pulses;
    int irqs;
    per = div + 1; ncyc = exp_q.size() * per;
    bad = 0; pulses = 0; irqs = 0;
    obs_q.delete();
    for (int c = 0; c < ncyc; c++) begin
      @(posedge PCLK); #1;
      if (TXD !== exp_q[c / per]) bad++;
      if (baud_o === 1'b1) pulses++;
      if (IRQ !== 1'b0) irqs++;
      if ((c % per) == per - 1) obs_q.push_back(TXD);
    end
    chk({tag, "_wave_bad_cycles"}, 32'(bad), 32'd0);
    chk({tag, "_baud_pulses"}, 32'(pulses), 32'(exp_q.size()));
    chk({tag, "_irq_in_frame"}, 32'(irqs), 32'd0);
    exp_q.delete();
    @(posedge PCLK); #1;
    chk({tag, "_txd_idle_after"}, 32'(TXD), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    logic [6:0]  c;
    logic [7:0]  d;
    int          dv;

    checks = 0; failures = 0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_txd", 32'(TXD), 32'd1);
    chk("rst_irq", 32'(IRQ), 32'd0);
    chk("rst_baud", 32'(baud_o), 32'd0);
    chk("rst_pslverr", 32'(PSLVERR), 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_pready", 32'(PREADY), 32'd1);
    @(negedge PCLK); PRESETn = 1'b1;
    rd(32'h4, r);  chk("rst_status", r, 32'h0000_0002);
    rd(32'h8, r);  chk("rst_ctrl", r, 32'h0);
    rd(32'hC, r);  chk("rst_baudreg", r, 32'h0);

    // 8N1, divisor 3, 0x55
    wr(32'hC, 32'd3); wr(32'h8, 32'h07); wr(32'h0, 32'h55);
    model_frame(8'h55, 7'h07);
    run_frames("f55", 3);
    rd(32'h4, r); chk("f55_status_idle", r, 32'h0000_0002);

    // reset in the middle of a frame forces the line idle at once
    wr(32'h0, 32'h55);
    repeat (9) begin @(posedge PCLK); #1; end
    chk("pre_rst_txd", 32'(TXD), 32'd0);
    #2 PRESETn = 1'b0;
    #1 chk("async_rst_txd", 32'(TXD), 32'd1);
    @(negedge PCLK); PRESETn = 1'b1;
    rd(32'h4, r); chk("post_rst_status", r, 32'h0000_0002);

    // 8 bits, even parity, then odd parity
    wr(32'hC, 32'd0); wr(32'h8, 32'h1F); wr(32'h0, 32'h07);
    model_frame(8'h07, 7'h1F);
    run_frames("par_even", 0);
    chk("par_even_bit", 32'(obs_q[9]), 32'd1);
    wr(32'h8, 32'h0F); wr(32'h0, 32'h07);
    model_frame(8'h07, 7'h0F);
    run_frames("par_odd", 0);
    chk("par_odd_bit", 32'(obs_q[9]), 32'd0);

    // 5 bits, 2 stop bits, divisor 1
    wr(32'hC, 32'd1); wr(32'h8, 32'h21); wr(32'h0, 32'hFF);
    model_frame(8'hFF, 7'h21);
    run_frames("f5s2", 1);

    // two queued bytes sent back-to-back once enabled
    wr(32'h8, 32'h20); wr(32'h0, 32'hA5); wr(32'h0, 32'h3C);
    rd(32'h4, r); chk("b2b_level2", r, 32'h0000_0200);
    wr(32'h8, 32'h21);
    model_frame(8'hA5, 7'h21); model_frame(8'h3C, 7'h21);
    run_frames("b2b", 1);

    // overflow: 17 pushes into a 16-deep FIFO with transmit disabled
    wr(32'h8, 32'h00);
    for (int i = 0; i < 17; i++) wr(32'h0, 32'($urandom_range(255, 0)));
    rd(32'h4, r); chk("ovf_status", r, 32'h0000_1009);
    wr(32'h4, 32'h08);
    rd(32'h4, r); chk("ovf_cleared", r, 32'h0000_1001);
    @(negedge PCLK); PRESETn = 1'b0;
    @(negedge PCLK); PRESETn = 1'b1;

    // unmapped access
    wr(32'h8, 32'h06); wr(32'hC, 32'h1234);
    apb(1'b1, 32'h10, 32'hFFFF_FFFF, r, e); chk("slverr_wr_unmapped", 32'(e), 32'd1);
    apb(1'b0, 32'h8, 32'h0, r, e);
    chk("slverr_mapped", 32'(e), 32'd0);
    chk("ctrl_unchanged", r, 32'h06);
    rd(32'hC, r); chk("baud_unchanged", r, 32'h1234);
    apb(1'b0, 32'h14, 32'h0, r, e);
    chk("slverr_rd_unmapped", 32'(e), 32'd1);
    chk("rdata_unmapped", r, 32'd0);
    rd(32'h0, r); chk("txdata_reads_zero", r, 32'd0);

    // empty interrupt
    wr(32'hC, 32'd0); wr(32'h8, 32'h47);
    @(posedge PCLK); #1;
    chk("irq_idle_empty", 32'(IRQ), 32'd1);
    wr(32'h0, 32'h3A);
    model_frame(8'h3A, 7'h47);
    run_frames("irq", 0);
    chk("irq_lag_one", 32'(IRQ), 32'd0);
    @(posedge PCLK); #1;
    chk("irq_rise", 32'(IRQ), 32'd1);

    // randomized single frames
    for (int k = 0; k < 8; k++) begin
      c  = {1'b0, 5'($urandom_range(31, 0)), 1'b1};
      d  = 8'($urandom_range(255, 0));
      dv = int'($urandom_range(3, 0));
      wr(32'hC, 32'(dv)); wr(32'h8, 32'(c)); wr(32'h0, 32'(d));
      model_frame(d, c);
      run_frames($sformatf("rnd%0d", k), dv);
      rd(32'h4, r); chk($sformatf("rnd%0d_status", k), r, 32'h0000_0002);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
